// File: rtl/scr1_dp_memory_hs.sv
// rtl/scr1_dp_memory_hs.sv - dual-port TCM array with byte-enable writes and per-port req/rdy/rvalid/rack handshake
//
// Optional feature macro: SCR1_DPMEM_OUTREG_EN adds a stage-1 register between
// the array read and each port's response register (latency 2, two outstanding).
// Port A is read-only, port B is read/write. The response registers hold their
// data until acked, so later array writes never disturb a pending response.

module scr1_dp_memory_hs #(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_SIZE   = 32'h00010000,
    localparam int SCR1_NBYTES = SCR1_WIDTH / 8,
    localparam int AW          = $clog2(SCR1_SIZE / SCR1_NBYTES)
) (
    input  logic                   clk,
    input  logic                   rst,
    // port A: instruction side, read-only
    input  logic                   a_req,
    output logic                   a_rdy,
    input  logic [AW-1:0]          a_addr,
    output logic                   a_rvalid,
    input  logic                   a_rack,
    output logic [SCR1_WIDTH-1:0]  a_rdata,
    // port B: data side, read/write
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [SCR1_NBYTES-1:0] b_be,
    input  logic [AW-1:0]          b_addr,
    input  logic [SCR1_WIDTH-1:0]  b_wdata,
    output logic                   b_rdy,
    output logic                   b_rvalid,
    input  logic                   b_rack,
    output logic [SCR1_WIDTH-1:0]  b_rdata
);

    localparam int DEPTH = SCR1_SIZE / SCR1_NBYTES;

    logic [SCR1_WIDTH-1:0] mem_q [0:DEPTH-1];

    logic                  a_rvalid_q, a_rvalid_d;
    logic [SCR1_WIDTH-1:0] a_rdata_q,  a_rdata_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [SCR1_WIDTH-1:0] b_rdata_q,  b_rdata_d;

    logic                  a_adv, b_adv;
    logic                  a_acc, b_acc;
    logic                  b_wr_acc, b_rd_acc;
    logic                  collide;
    logic [SCR1_WIDTH-1:0] a_word;
    logic [SCR1_WIDTH-1:0] b_word;

    // A response register may take new data when it is empty or being acked
    assign a_adv = ~a_rvalid_q | a_rack;
    assign b_adv = ~b_rvalid_q | b_rack;

`ifdef SCR1_DPMEM_OUTREG_EN
    logic                  a_s1_valid_q, a_s1_valid_d;
    logic [SCR1_WIDTH-1:0] a_s1_data_q,  a_s1_data_d;
    logic                  b_s1_valid_q, b_s1_valid_d;
    logic [SCR1_WIDTH-1:0] b_s1_data_q,  b_s1_data_d;

    // Stage 1 can accept when empty or when it drains into the response register
    assign a_rdy = ~rst & (~a_s1_valid_q | a_adv);
    assign b_rdy = ~rst & (~b_s1_valid_q | b_adv);
`else
    assign a_rdy = ~rst & a_adv;
    assign b_rdy = ~rst & b_adv;
`endif

    assign a_acc    = a_req & a_rdy;
    assign b_acc    = b_req & b_rdy;
    assign b_wr_acc = b_acc & b_we;
    assign b_rd_acc = b_acc & ~b_we;
    assign collide  = b_wr_acc & (b_addr == a_addr);

    // Read words; an A read colliding with a B write sees the write-first merge
    always_comb begin
        a_word = mem_q[a_addr];
        b_word = mem_q[b_addr];
        if (collide) begin
            for (int i = 0; i < SCR1_NBYTES; i++) begin
                if (b_be[i]) begin
                    a_word[i*8 +: 8] = b_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Array write with per-lane enables; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (b_wr_acc && !rst) begin
            for (int i = 0; i < SCR1_NBYTES; i++) begin
                if (b_be[i]) begin
                    mem_q[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                end
            end
        end
    end

`ifdef SCR1_DPMEM_OUTREG_EN
    // Next state for stage 1 and the response registers of both ports
    always_comb begin
        a_s1_valid_d = a_s1_valid_q;
        a_s1_data_d  = a_s1_data_q;
        b_s1_valid_d = b_s1_valid_q;
        b_s1_data_d  = b_s1_data_q;
        a_rvalid_d   = a_rvalid_q;
        a_rdata_d    = a_rdata_q;
        b_rvalid_d   = b_rvalid_q;
        b_rdata_d    = b_rdata_q;

        if (a_s1_valid_q && a_adv) begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = a_s1_data_q;
        end else if (a_rack) begin
            a_rvalid_d = 1'b0;
        end
        if (a_acc) begin
            a_s1_valid_d = 1'b1;
            a_s1_data_d  = a_word;
        end else if (a_adv) begin
            a_s1_valid_d = 1'b0;
        end

        if (b_s1_valid_q && b_adv) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = b_s1_data_q;
        end else if (b_rack) begin
            b_rvalid_d = 1'b0;
        end
        if (b_rd_acc) begin
            b_s1_valid_d = 1'b1;
            b_s1_data_d  = b_word;
        end else if (b_adv) begin
            b_s1_valid_d = 1'b0;
        end
    end

    // Stage 1 registers; reset drops any read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_valid_q <= 1'b0;
            a_s1_data_q  <= '0;
            b_s1_valid_q <= 1'b0;
            b_s1_data_q  <= '0;
        end else begin
            a_s1_valid_q <= a_s1_valid_d;
            a_s1_data_q  <= a_s1_data_d;
            b_s1_valid_q <= b_s1_valid_d;
            b_s1_data_q  <= b_s1_data_d;
        end
    end
`else
    // Next state for the response registers, loaded straight from the array
    always_comb begin
        a_rvalid_d = a_rvalid_q;
        a_rdata_d  = a_rdata_q;
        b_rvalid_d = b_rvalid_q;
        b_rdata_d  = b_rdata_q;

        if (a_acc) begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = a_word;
        end else if (a_rack) begin
            a_rvalid_d = 1'b0;
        end

        if (b_rd_acc) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = b_word;
        end else if (b_rack) begin
            b_rvalid_d = 1'b0;
        end
    end
`endif

    // Response registers; rdata only changes when a new response is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_scr1_dp_memory_hs.sv
// tb/tb_scr1_dp_memory_hs.sv - self-checking bench for scr1_dp_memory_hs against a queue-based model

module tb_scr1_dp_memory_hs;

    localparam int W  = 32;
    localparam int NB = 4;
    localparam int AW = 14;
`ifdef SCR1_DPMEM_OUTREG_EN
    localparam int LAT = 2;
    localparam int MAX = 2;
`else
    localparam int LAT = 1;
    localparam int MAX = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0;
    logic          a_rdy;
    logic [AW-1:0] a_addr = '0;
    logic          a_rvalid;
    logic          a_rack = 1'b1;
    logic [W-1:0]  a_rdata;
    logic          b_req = 1'b0;
    logic          b_we = 1'b0;
    logic [NB-1:0] b_be = '0;
    logic [AW-1:0] b_addr = '0;
    logic [W-1:0]  b_wdata = '0;
    logic          b_rdy;
    logic          b_rvalid;
    logic          b_rack = 1'b1;
    logic [W-1:0]  b_rdata;

    scr1_dp_memory_hs dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_rdy    (a_rdy),
        .a_addr   (a_addr),
        .a_rvalid (a_rvalid),
        .a_rack   (a_rack),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_be     (b_be),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_rdy    (b_rdy),
        .b_rvalid (b_rvalid),
        .b_rack   (b_rack),
        .b_rdata  (b_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } rsp_t;

    rsp_t         qa[$];
    rsp_t         qb[$];
    logic [W-1:0] mem_m [0:63];
    int           cyc = 0;
    int           lpa = -100;
    int           lpb = -100;
    int           n_cmp = 0;
    int           n_err = 0;
    int           na_rsp = 0;
    int           nb_rsp = 0;
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Earliest cycle a queued response may be visible: fixed latency after
    // acceptance, and never before the cycle after the previous one was acked.
    function automatic int due(input int acc, input int lp);
        return (acc + LAT > lp + 1) ? acc + LAT : lp + 1;
    endfunction

    task automatic tick();
        logic         rva, rvb, rdya, rdyb, acca, accb;
        logic [W-1:0] w;
        #1;
        rva  = (qa.size() > 0) && (cyc >= due(qa[0].acc, lpa));
        rvb  = (qb.size() > 0) && (cyc >= due(qb[0].acc, lpb));
        rdya = !rst && ((qa.size() < MAX) || (rva && a_rack));
        rdyb = !rst && ((qb.size() < MAX) || (rvb && b_rack));
        chk("a_rvalid", 32'(a_rvalid), 32'(rva));
        chk("b_rvalid", 32'(b_rvalid), 32'(rvb));
        chk("a_rdy", 32'(a_rdy), 32'(rdya));
        chk("b_rdy", 32'(b_rdy), 32'(rdyb));
        if (rva && a_rack) begin
            chk("a_rdata", a_rdata, qa[0].data);
            last_a = a_rdata;
            na_rsp++;
            void'(qa.pop_front());
            lpa = cyc;
        end
        if (rvb && b_rack) begin
            chk("b_rdata", b_rdata, qb[0].data);
            last_b = b_rdata;
            nb_rsp++;
            void'(qb.pop_front());
            lpb = cyc;
        end
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            acca = a_req && rdya;
            accb = b_req && rdyb;
            if (acca) begin
                w = mem_m[a_addr[5:0]];
                if (accb && b_we && (b_addr == a_addr)) begin
                    for (int i = 0; i < NB; i++) begin
                        if (b_be[i]) w[i*8 +: 8] = b_wdata[i*8 +: 8];
                    end
                end
                qa.push_back('{w, cyc});
            end
            if (accb) begin
                if (b_we) begin
                    for (int i = 0; i < NB; i++) begin
                        if (b_be[i]) mem_m[b_addr[5:0]][i*8 +: 8] = b_wdata[i*8 +: 8];
                    end
                end else begin
                    qb.push_back('{mem_m[b_addr[5:0]], cyc});
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        a_req  = 1'b0;
        b_req  = 1'b0;
        b_we   = 1'b0;
        a_rack = 1'b1;
        b_rack = 1'b1;
    endtask

    task automatic set_a(input logic [AW-1:0] addr);
        a_req  = 1'b1;
        a_addr = addr;
    endtask

    task automatic set_b(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] addr,
                         input logic [W-1:0] wdata);
        b_req   = 1'b1;
        b_we    = we;
        b_be    = be;
        b_addr  = addr;
        b_wdata = wdata;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 8; i++) tick();
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        int na0, nb0;
        @(negedge clk);
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);

        // clear the words the bench uses
        for (int i = 0; i < 64; i++) begin
            set_b(1'b1, 4'hF, AW'(i), 32'h0);
            tick();
        end
        idle();

        // full write then A read
        set_b(1'b1, 4'hF, 14'h10, 32'hDEADBEEF);
        tick();
        idle();
        set_a(14'h10);
        tick();
        idle();
        drain();
        chk("wr_rd_a", last_a, 32'hDEADBEEF);

        // partial write then B read
        set_b(1'b1, 4'b0101, 14'h10, 32'h11223344);
        tick();
        set_b(1'b0, 4'h0, 14'h10, 32'h0);
        tick();
        drain();
        chk("partial_b", last_b, 32'hDE22BE44);

        // zero byte-enable write is a no-op
        set_b(1'b1, 4'h0, 14'h10, 32'hFFFFFFFF);
        tick();
        set_b(1'b0, 4'h0, 14'h10, 32'h0);
        tick();
        drain();
        chk("be_zero", last_b, 32'hDE22BE44);

        // same-edge collision merges new lanes over old data
        set_a(14'h20);
        set_b(1'b1, 4'b1100, 14'h20, 32'hAABBCCDD);
        tick();
        drain();
        chk("collide_a", last_a, 32'hAABB0000);

        // back-pressure: response frozen while the word is rewritten
        na0 = na_rsp;
        set_a(14'h30);
        tick();
        a_req  = 1'b0;
        a_rack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_b(1'b1, 4'hF, 14'h30, $urandom);
            tick();
        end
        chk("held_rdata", a_rdata, 32'h0);
        idle();
        drain();
        chk("held_one_rsp", 32'(na_rsp - na0), 32'd1);
        chk("held_last_a", last_a, 32'h0);

        // back-to-back reads on both ports, one per cycle
        na0 = na_rsp;
        nb0 = nb_rsp;
        for (int i = 0; i < 16; i++) begin
            set_a(AW'(i));
            set_b(1'b0, 4'h0, AW'(i + 16), 32'h0);
            tick();
        end
        drain();
        chk("b2b_a_cnt", 32'(na_rsp - na0), 32'd16);
        chk("b2b_b_cnt", 32'(nb_rsp - nb0), 32'd16);

        // randomized traffic over a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            a_req   = 1'($urandom_range(0, 1));
            a_addr  = AW'($urandom_range(0, 7));
            b_req   = 1'($urandom_range(0, 1));
            b_we    = 1'($urandom_range(0, 1));
            b_be    = NB'($urandom);
            b_addr  = AW'($urandom_range(0, 7));
            b_wdata = $urandom;
            a_rack  = ($urandom_range(0, 3) != 0);
            b_rack  = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // reset with a read outstanding discards it
        a_rack = 1'b0;
        set_a(14'h05);
        set_b(1'b0, 4'h0, 14'h06, 32'h0);
        tick();
        a_req = 1'b0;
        b_req = 1'b0;
        b_rack = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        rst = 1'b1;
        set_b(1'b1, 4'hF, 14'h07, 32'h12345678);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_out_a_rdata", a_rdata, 32'h0);
        chk("rst_out_b_rdata", b_rdata, 32'h0);
        na0 = na_rsp;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_no_rsp", 32'(na_rsp - na0), 32'd0);
        set_b(1'b0, 4'h0, 14'h07, 32'h0);
        tick();
        drain();
        chk("rst_no_write", last_b, mem_m[7]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
